// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Multiplexed display scan controller. It steps through the enabled digits of
// an 8-digit common-anode display. Each digit slot has two parts. First comes
// a blanking interval with all anodes off. Then comes a show interval with only
// the addressed digit's anode driven low.
// The digit select S drives an external 8-to-1 mux. The selected segment code
// comes back on d and is latched into code on the last blanking cycle.
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous active-high reset
//   en        in   scan enable
//   digit_en  in   [7:0] per-digit enable mask
//   d         in   [N-1:0] segment code of the digit addressed by S
//   S         out  [2:0] digit select (registered)
//   AN        out  [7:0] active-low anode drives (registered)
//   code      out  [N-1:0] latched segment code of the shown digit (registered)
//   frame     out  one-cycle pulse when the scan wraps (registered)
module seg_scan_ctrl #(
    parameter int N        = 6,
    parameter int PRESCALE = 100000,
    parameter int BLANK    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [7:0]   digit_en,
    input  logic [N-1:0] d,
    output logic [2:0]   S,
    output logic [7:0]   AN,
    output logic [N-1:0] code,
    output logic         frame
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     s_q, s_d;
    logic [7:0]     an_q, an_d;
    logic [N-1:0]   code_q, code_d;
    logic           frame_q, frame_d;

    // Lowest set index of the mask (mask assumed non-zero).
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    // Next set index strictly above cur, wrapping circularly.
    // If no other bit is set, cur itself is returned.
    function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] idx;
        r = cur;
        // Descending offset, so the nearest set bit is the one that sticks.
        for (int k = 7; k >= 1; k--) begin
            idx = cur + 3'(k);
            if (m[idx]) begin
                r = idx;
            end
        end
        return r;
    endfunction

    // Anode pattern for the addressed digit, off if that digit is disabled.
    function automatic logic [7:0] anode_for(input logic [7:0] m, input logic [2:0] sel);
        logic [7:0] r;
        if (m[sel]) begin
            r = ~(8'h01 << sel);
        end else begin
            r = 8'hFF;
        end
        return r;
    endfunction

    // Next-state, slot counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        s_d     = s_q;
        an_d    = 8'hFF;
        code_d  = code_q;
        frame_d = 1'b0;
        if (!en || (digit_en == 8'h00)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    s_d     = lowest_set(digit_en);
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        // S has been stable for the whole blank, so d has settled.
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        code_d  = d;
                        an_d    = anode_for(digit_en, s_q);
                    end else begin
                        an_d    = 8'hFF;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        s_d     = next_set(digit_en, s_q);
                        // A non-increasing step means the scan wrapped.
                        frame_d = (s_d <= s_q);
                    end else begin
                        an_d    = anode_for(digit_en, s_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_q     <= 3'd0;
            an_q    <= 8'hFF;
            code_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            an_q    <= an_d;
            code_q  <= code_d;
            frame_q <= frame_d;
        end
    end

    assign S     = s_q;
    assign AN    = an_q;
    assign code  = code_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with PRESCALE=10, BLANK=2 and N=6.
// Each slot lasts 10 cycles: 2 blank cycles with AN=FF, then 8 show cycles
// with AN=~(1<<S). Inputs are driven and outputs are sampled on the falling
// edge of the clock.
module tb_seg_scan_ctrl;

    localparam int N = 6;
    localparam int P = 10;
    localparam int B = 2;

    logic         clk;
    logic         reset;
    logic         en;
    logic [7:0]   digit_en;
    logic [N-1:0] d;
    logic [2:0]   S;
    logic [7:0]   AN;
    logic [N-1:0] code;
    logic         frame;

    int vec_cnt;
    int err_cnt;

    seg_scan_ctrl #(.N(N), .PRESCALE(P), .BLANK(B)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .digit_en (digit_en),
        .d        (d),
        .S        (S),
        .AN       (AN),
        .code     (code),
        .frame    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 8-to-1 digit mux: a fixed segment code per digit.
    function automatic logic [5:0] mux_d(input logic [2:0] sel);
        logic [5:0] r;
        case (sel)
            3'd0:    r = 6'h15;
            3'd1:    r = 6'h01;
            3'd2:    r = 6'h2A;
            3'd3:    r = 6'h03;
            3'd4:    r = 6'h04;
            3'd5:    r = 6'h05;
            3'd6:    r = 6'h06;
            3'd7:    r = 6'h07;
            default: r = 6'h00;
        endcase
        return r;
    endfunction

    always_comb d = mux_d(S);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_onehot();
        chk("an_onehot", 32'($countones(~AN) <= 1), 32'd1);
    endtask

    // Sample slot positions lo..hi of a slot showing digit s.
    // fr is the expected frame value at position 0.
    // gated forces the expected AN to FF during the show part.
    task automatic slot(input int s, input bit fr, input int lo, input int hi, input bit gated);
        logic [7:0] exp_an;
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            exp_an = (i < B || gated) ? 8'hFF : ~(8'h01 << s);
            chk($sformatf("an s%0d p%0d", s, i), 32'(AN), 32'(exp_an));
            chk($sformatf("sel s%0d p%0d", s, i), 32'(S), 32'(s));
            chk($sformatf("frame s%0d p%0d", s, i), 32'(frame), (i == 0) ? 32'(fr) : 32'd0);
            if (i >= B) begin
                chk($sformatf("code s%0d p%0d", s, i), 32'(code), 32'(mux_d(3'(s))));
            end
            chk_onehot();
        end
    endtask

    // Drop en at a slot boundary; the block must be idle after one edge.
    task automatic go_idle(input int exp_s, input logic [5:0] exp_code);
        en = 1'b0;
        @(negedge clk);
        chk("idle_an", 32'(AN), 32'h000000FF);
        chk("idle_frame", 32'(frame), 32'd0);
        chk("idle_sel", 32'(S), 32'(exp_s));
        chk("idle_code", 32'(code), 32'(exp_code));
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        reset    = 1'b1;
        en       = 1'b0;
        digit_en = 8'h00;

        // Reset state.
        @(negedge clk);
        chk("rst_an", 32'(AN), 32'h000000FF);
        chk("rst_sel", 32'(S), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_frame", 32'(frame), 32'd0);

        // en=1 with an empty mask stays idle.
        reset = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        chk("empty_an", 32'(AN), 32'h000000FF);
        chk("empty_frame", 32'(frame), 32'd0);
        chk("empty_sel", 32'(S), 32'd0);

        // Full scan: 0..7, then a wrap to 0 with a frame pulse.
        digit_en = 8'hFF;
        for (int s = 0; s < 8; s++) begin
            slot(s, 1'b0, 0, P - 1, 1'b0);
        end
        slot(0, 1'b1, 0, P - 1, 1'b0);
        go_idle(0, 6'h15);

        // Skip mask: 0, 2, 7, then a wrap to 0.
        digit_en = 8'b1000_0101;
        en       = 1'b1;
        slot(0, 1'b0, 0, P - 1, 1'b0);
        slot(2, 1'b0, 0, P - 1, 1'b0);
        slot(7, 1'b0, 0, P - 1, 1'b0);
        slot(0, 1'b1, 0, P - 1, 1'b0);
        go_idle(0, 6'h15);

        // Single digit: S stays 4 and frame pulses every slot.
        digit_en = 8'h10;
        en       = 1'b1;
        slot(4, 1'b0, 0, P - 1, 1'b0);
        slot(4, 1'b1, 0, P - 1, 1'b0);
        slot(4, 1'b1, 0, P - 1, 1'b0);

        // Clear the shown digit mid-SHOW: AN goes off on the next edge.
        // The scan then moves to digit 0 with a wrap.
        slot(4, 1'b1, 0, 3, 1'b0);
        digit_en = 8'h01;
        slot(4, 1'b0, 4, P - 1, 1'b1);
        slot(0, 1'b1, 0, P - 1, 1'b0);

        // Reset asserted mid-SHOW: anodes go off with no clock edge.
        slot(0, 1'b1, 0, 3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_an", 32'(AN), 32'h000000FF);
        chk("async_rst_sel", 32'(S), 32'd0);
        chk("async_rst_code", 32'(code), 32'd0);
        chk("async_rst_frame", 32'(frame), 32'd0);
        chk_onehot();

        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        chk("post_rst_an", 32'(AN), 32'h000000FF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N, default 6: width of the per-digit segment code.
REQ-002 Parameter PRESCALE, default 100000: clock cycles per digit slot, blanking included; SHALL be at least BLANK+2.
REQ-003 Parameter BLANK, default 8: all-anodes-off cycles at the start of each slot; SHALL be at least 1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  scan enable.
REQ-007 digit_en  input  8  per-digit enable mask; bit i enables digit i.
REQ-008 d  input  N  segment code for the digit currently addressed by S, supplied by the 8-to-1 digit mux.
REQ-009 S  output  3  digit select driven to the mux select input; registered.
REQ-010 AN  output  8  anode drives, active-low; registered.
REQ-011 code  output  N  latched segment code for the displayed digit; registered.
REQ-012 frame  output  1  one-cycle pulse when the scan wraps to a lower or equal digit index; registered.

Function
REQ-013 The block SHALL implement three states: IDLE, BLANK and SHOW.
REQ-014 A single slot counter SHALL count clk cycles within BLANK and within SHOW, and SHALL clear on every state change.
REQ-015 IDLE SHALL hold AN=8'hFF and frame=0; when en=1 and digit_en!=0, next state is BLANK and S loads the lowest set index of digit_en.
REQ-016 BLANK SHALL hold AN=8'hFF for exactly BLANK cycles, then move to SHOW.
REQ-017 On the last BLANK cycle, code SHALL load d; d is therefore sampled at least BLANK-1 cycles after S settles.
REQ-018 SHOW SHALL last PRESCALE-BLANK cycles, with AN[S]=0 and all other AN bits 1, gated as in REQ-019.
REQ-019 During SHOW, AN[S] SHALL be 0 only while digit_en[S]=1; when that bit clears mid-slot, AN SHALL return to 8'hFF on the next edge.
REQ-020 At the end of SHOW, S SHALL advance to the next set bit of digit_en above S, wrapping 7->0 circularly; next state is BLANK.
REQ-021 When the new S is less than or equal to the old S, frame SHALL be 1 for exactly that one cycle; it is 0 at all other times.
REQ-022 With a single enabled digit, S SHALL stay unchanged and frame SHALL pulse once per slot.
REQ-023 When en=0 or digit_en=0 is sampled in any state, the next state SHALL be IDLE with AN=8'hFF and the slot counter cleared.
REQ-024 In IDLE, S and code SHALL hold their last values.
REQ-025 Latency: from en rising at edge t, AN SHALL be 8'hFF from t+1, and the first digit's anode SHALL go low at edge t+1+BLANK.
REQ-026 Under no condition SHALL more than one AN bit be 0 at the same time.
REQ-027 S SHALL change only on the BLANK entry edge, so S never changes while any anode is active.

Reset
REQ-028 When reset=1, asynchronously: state=IDLE, slot counter=0, S=3'd0, AN=8'hFF, code=0, frame=0.
REQ-029 After reset deasserts, the first possible state change is at the next rising edge, evaluated per REQ-015.
REQ-030 When reset asserts mid-SHOW, AN SHALL go to 8'hFF immediately, without waiting for a clock edge.

Verification (PRESCALE=10, BLANK=2, N=6)
REQ-031 Full scan: digit_en=8'hFF, en=1 from edge 0. S steps 0..7 every 10 cycles; AN pattern is 2 cycles 8'hFF then 8 cycles ~(1<<S); frame pulses on the 7->0 wrap only.
REQ-032 Skip mask: digit_en=8'b1000_0101. S sequence is 0,2,7,0 and frame pulses on the 7->0 wrap; AN bits 1 and 3-6 never go low.
REQ-033 Code capture: d=6'h15 while S=0 and d=6'h2A while S=2. code equals 6'h15 during S=0's SHOW and 6'h2A during S=2's SHOW, loaded on the last BLANK cycle.
REQ-034 Single digit: digit_en=8'h10. S stays 4, frame pulses every 10 cycles, and AN alternates between 8'hFF and 8'hEF.
REQ-035 Mid-slot events: clear digit_en[S] during SHOW, and AN goes to 8'hFF on the next edge. Drop en, and the block reaches IDLE next cycle. Assert reset mid-SHOW, and AN=8'hFF with no clock edge.
REQ-036 Every scenario SHALL check, each cycle, that no more than one AN bit is 0.
